// File: rtl/gate_filter_pkg.sv
// Shared defaults and sizing helpers for the gate-output filter.
// Latency: n/a (constants and functions only).
// Backpressure: none; consumers are purely synchronous observers.
package gate_filter_pkg;

    localparam int N_CH_DEF          = 3;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 8;

    // Width of the qualification counter that must reach stable_cycles-1.
    function automatic int stab_w(input int stable_cycles);
        return $clog2(stable_cycles) + 1;
    endfunction

endpackage

// File: rtl/gate_filter_ch.sv
// One channel: 2-flop synchroniser, glitch qualifier, edge pulses and counters.
// Latency: STABLE_CYCLES+2 posedges from sampling edge to filt (pulse alongside).
// Backpressure: none; GATE_FILTER_GLITCH_CNT_EN adds a rejected-glitch counter.
module gate_filter_ch
    import gate_filter_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             cnt_clr,
    output logic             filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
`ifdef GATE_FILTER_GLITCH_CNT_EN
    output logic [CNT_W-1:0] glitch_cnt,
`endif
    output logic             settled
);

    localparam int              SW        = stab_w(STABLE_CYCLES);
    localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic          s1;
    logic          s2;
    logic [SW-1:0] stab_cnt;
    logic          commit;

    assign settled = (s2 == filt);
    assign commit  = (s2 != filt) && (stab_cnt == STAB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            filt       <= 1'b0;
            stab_cnt   <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (s2 == filt) begin
                stab_cnt <= '0;
            end else if (commit) begin
                filt       <= s2;
                stab_cnt   <= '0;
                rise_pulse <= s2;
                fall_pulse <= ~s2;
            end else begin
                stab_cnt <= stab_cnt + SW'(1);
            end
        end
    end

    // Clear takes priority over a same-cycle commit, so that edge is lost.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            edge_cnt <= '0;
        end else if (commit && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

`ifdef GATE_FILTER_GLITCH_CNT_EN
    logic glitch;

    // A partially qualified change that collapsed back to the settled value.
    assign glitch = (s2 == filt) && (stab_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != CNT_MAX)) begin
            glitch_cnt <= glitch_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/gate_output_filter.sv
// Filters N_CH asynchronous gate outputs into settled, debounced values.
// Latency: STABLE_CYCLES+2 posedges per channel; no backpressure (observer only).
// GATE_FILTER_GLITCH_CNT_EN adds the packed glitch_cnt output.
module gate_output_filter
    import gate_filter_pkg::*;
#(
    parameter int N_CH          = N_CH_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_in,
    input  logic                  cnt_clr,
    output logic [N_CH-1:0]       filt_out,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH-1:0]       fall_pulse,
    output logic [N_CH*CNT_W-1:0] edge_cnt,
`ifdef GATE_FILTER_GLITCH_CNT_EN
    output logic [N_CH*CNT_W-1:0] glitch_cnt,
`endif
    output logic                  all_settled
);

    logic [N_CH-1:0] ch_settled;

    assign all_settled = &ch_settled;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gate_filter_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sig_in     (sig_in[i]),
            .cnt_clr    (cnt_clr),
            .filt       (filt_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .edge_cnt   (edge_cnt[i*CNT_W +: CNT_W]),
`ifdef GATE_FILTER_GLITCH_CNT_EN
            .glitch_cnt (glitch_cnt[i*CNT_W +: CNT_W]),
`endif
            .settled    (ch_settled[i])
        );
    end

endmodule

// File: tb/tb_gate_output_filter.sv
// Directed bench for gate_output_filter (3 channels, STABLE_CYCLES=4, CNT_W=2).
// Inputs driven and outputs sampled on the negedge; checks via immediate assertions.
module tb_gate_output_filter;

    logic       clk;
    logic       rst;
    logic [2:0] sig_in;
    logic       cnt_clr;
    logic [2:0] filt_out;
    logic [2:0] rise_pulse;
    logic [2:0] fall_pulse;
    logic [5:0] edge_cnt;
`ifdef GATE_FILTER_GLITCH_CNT_EN
    logic [5:0] glitch_cnt;
`endif
    logic       all_settled;

    int checks = 0;
    int errors = 0;

    gate_output_filter #(
        .N_CH          (3),
        .STABLE_CYCLES (4),
        .CNT_W         (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .cnt_clr     (cnt_clr),
        .filt_out    (filt_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .edge_cnt    (edge_cnt),
`ifdef GATE_FILTER_GLITCH_CNT_EN
        .glitch_cnt  (glitch_cnt),
`endif
        .all_settled (all_settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        int exp_cnt[5] = '{1, 2, 3, 3, 3};

        rst     = 1'b1;
        sig_in  = 3'b000;
        cnt_clr = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_filt",    32'(filt_out),    32'h0);
        check("rst_rise",    32'(rise_pulse),  32'h0);
        check("rst_fall",    32'(fall_pulse),  32'h0);
        check("rst_edge",    32'(edge_cnt),    32'h0);
        check("rst_settled", 32'(all_settled), 32'h1);

        // Clean step on channel 0: commit on the 6th posedge counting the sampling edge
        sig_in = 3'b001;
        tick(1);
        check("step_settled_p1", 32'(all_settled), 32'h1);
        tick(1);
        check("step_settled_p2", 32'(all_settled), 32'h0);
        tick(3);
        check("step_filt_p5",    32'(filt_out),    32'h0);
        check("step_rise_p5",    32'(rise_pulse),  32'h0);
        check("step_settled_p5", 32'(all_settled), 32'h0);
        tick(1);
        check("step_filt_p6",    32'(filt_out),    32'h1);
        check("step_rise_p6",    32'(rise_pulse),  32'h1);
        check("step_fall_p6",    32'(fall_pulse),  32'h0);
        check("step_settled_p6", 32'(all_settled), 32'h1);
        tick(1);
        check("step_rise_p7",    32'(rise_pulse),  32'h0);
        tick(3);
        check("step_edge",       32'(edge_cnt),    32'h01);

        // Two-cycle glitch on channel 2 must be rejected
        sig_in = 3'b101;
        tick(2);
        sig_in = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_filt",  32'(filt_out),                32'h1);
            check("glitch_pulse", 32'(rise_pulse | fall_pulse), 32'h0);
        end
        check("glitch_edge", 32'(edge_cnt), 32'h01);
`ifdef GATE_FILTER_GLITCH_CNT_EN
        check("glitch_cnt",  32'(glitch_cnt), 32'h10);
`endif

        // Channel 1 toggles: counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            bit odd;
            odd    = (k % 2) == 1;
            sig_in = odd ? 3'b011 : 3'b001;
            tick(6);
            check("sat_rise", 32'(rise_pulse), odd ? 32'h2 : 32'h0);
            check("sat_fall", 32'(fall_pulse), odd ? 32'h0 : 32'h2);
            tick(2);
            check("sat_filt", 32'(filt_out), odd ? 32'h3 : 32'h1);
            check("sat_cnt1", 32'(edge_cnt[3:2]), 32'(exp_cnt[k-1]));
        end
        check("sat_edge_all", 32'(edge_cnt), 32'h0D);

        // Clear collides with the 6th commit: clear wins, pulse still fires
        sig_in = 3'b001;
        tick(5);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("clr_fall", 32'(fall_pulse), 32'h2);
        check("clr_filt", 32'(filt_out),   32'h1);
        check("clr_edge", 32'(edge_cnt),   32'h00);

        // Reset in the middle of qualifying channel 1
        sig_in = 3'b000;
        tick(8);
        check("pre_rst_filt", 32'(filt_out), 32'h0);
        check("pre_rst_edge", 32'(edge_cnt), 32'h01);
        sig_in = 3'b010;
        tick(4);
        check("midq_filt", 32'(filt_out), 32'h0);
        rst = 1'b1;
        tick(1);
        check("in_rst_rise", 32'(rise_pulse), 32'h0);
        tick(1);
        check("in_rst_filt", 32'(filt_out),   32'h0);
        check("in_rst_edge", 32'(edge_cnt),   32'h00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("requal_rise", 32'(rise_pulse), 32'h0);
            check("requal_filt", 32'(filt_out),   32'h0);
        end
        tick(1);
        check("requal_filt_p6", 32'(filt_out),   32'h2);
        check("requal_rise_p6", 32'(rise_pulse), 32'h2);
        tick(3);
        check("requal_edge",    32'(edge_cnt),   32'h04);

        // All channels step together
        sig_in = 3'b000;
        tick(8);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("all_clr_edge", 32'(edge_cnt), 32'h00);
        sig_in = 3'b111;
        tick(5);
        check("all_rise_p5", 32'(rise_pulse), 32'h0);
        tick(1);
        check("all_rise_p6", 32'(rise_pulse), 32'h7);
        check("all_filt_p6", 32'(filt_out),   32'h7);
        tick(1);
        check("all_rise_p7", 32'(rise_pulse), 32'h0);
        check("all_edge",    32'(edge_cnt),   32'h15);
        check("all_settled", 32'(all_settled), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
